// File: rtl/irrigation_pkg.sv
// Shared definitions for the irrigation valve scheduler.
//   - FSM state encodings (3 bits) and state width
//   - valve mode constants
//   - helper deciding which states report busy
package irrigation_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE     = 3'd0;
    localparam logic [STATE_W-1:0] SETTLE   = 3'd1;
    localparam logic [STATE_W-1:0] RUN      = 3'd2;
    localparam logic [STATE_W-1:0] COOLDOWN = 3'd3;
    localparam logic [STATE_W-1:0] FAULT    = 3'd4;

    localparam logic MODE_DRIP     = 1'b0;
    localparam logic MODE_SPRINKLE = 1'b1;

    function automatic logic is_busy(input logic [STATE_W-1:0] s);
        return (s == SETTLE) || (s == RUN) || (s == COOLDOWN);
    endfunction

endpackage

// File: rtl/irrigation_scheduler_input_sync.sv
// input_sync: multi-bit 2-flop synchronizer, every flop resets to 0.
// Each bit is synchronized independently; no coherency between bits is implied.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   d [WIDTH]  : asynchronous inputs
//   q [WIDTH]  : synchronized outputs (2 cycles of latency)
module input_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [1:0][WIDTH-1:0] sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_pipe <= '0;
        end else begin
            sync_pipe[0] <= d;
            sync_pipe[1] <= sync_pipe[0];
        end
    end

    assign q = sync_pipe[1];

endmodule

// File: rtl/irrigation_scheduler.sv
// irrigation_scheduler: sequences the dripper / sprinkler valves once the
// upstream permit (irrigation_ok) has been stable for SETTLE_CYCLES samples,
// bounds each run to RUN_CYCLES, and enforces a COOLDOWN_CYCLES valve-off
// gap after every run. A sensor error forces FAULT until it clears.
//
// Optional build macro: IRRIGATION_SCHED_SYNC_EN
//   defined   -> irrigation_ok and error pass through 2-flop synchronizers
//                (all input-referred latencies +2 cycles)
//   undefined -> inputs feed the FSM directly
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   irrigation_ok  : permit from the prerequisite check
//   error          : sensor fault, highest priority
//   mode           : 0 = dripper, 1 = sprinkler (latched on entry to RUN)
//   dripper        : dripper valve enable (registered)
//   sprinkler      : sprinkler valve enable (registered)
//   busy           : high in SETTLE / RUN / COOLDOWN
//   fault          : high in FAULT
//   done           : one-cycle pulse after a full-length run
//   state [3]      : current state encoding
import irrigation_pkg::*;

module irrigation_scheduler #(
    parameter int SETTLE_CYCLES   = 4,
    parameter int RUN_CYCLES      = 16,
    parameter int COOLDOWN_CYCLES = 8,
    parameter int CNT_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               irrigation_ok,
    input  logic               error,
    input  logic               mode,
    output logic               dripper,
    output logic               sprinkler,
    output logic               busy,
    output logic               fault,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    // Thresholds widened by one bit so cnt+1 / cnt+2 never overflow the compare.
    localparam logic [CNT_W:0] SETTLE_N = (CNT_W+1)'(SETTLE_CYCLES);
    localparam logic [CNT_W:0] RUN_N    = (CNT_W+1)'(RUN_CYCLES);
    localparam logic [CNT_W:0] COOL_N   = (CNT_W+1)'(COOLDOWN_CYCLES);
    localparam bit SETTLE_ONE = (SETTLE_CYCLES == 1);

    logic ok_s;
    logic err_s;

`ifdef IRRIGATION_SCHED_SYNC_EN
    logic [1:0] sync_q;

    input_sync #(.WIDTH(2)) u_input_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({error, irrigation_ok}),
        .q     (sync_q)
    );

    assign ok_s  = sync_q[0];
    assign err_s = sync_q[1];
`else
    assign ok_s  = irrigation_ok;
    assign err_s = error;
`endif

    logic [CNT_W-1:0]   cnt;
    logic               mode_q;

    logic [CNT_W:0]     cnt_p1;
    logic [CNT_W:0]     cnt_p2;
    logic [CNT_W-1:0]   cnt_sat;

    logic [STATE_W-1:0] nxt_state;
    logic [CNT_W-1:0]   nxt_cnt;
    logic               nxt_mode;
    logic               nxt_run;
    logic               nxt_done;

    assign cnt_p1  = {1'b0, cnt} + (CNT_W+1)'(1);
    assign cnt_p2  = {1'b0, cnt} + (CNT_W+1)'(2);
    // Saturate at all-ones instead of wrapping.
    assign cnt_sat = (cnt == '1) ? cnt : cnt_p1[CNT_W-1:0];

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt_sat;
        nxt_mode  = mode_q;
        nxt_run   = 1'b0;
        nxt_done  = 1'b0;

        if (err_s) begin
            nxt_state = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    // The entry sample is permit sample 1; with a
                    // single-sample settle it already completes the settle.
                    if (ok_s) begin
                        if (SETTLE_ONE) begin
                            nxt_state = RUN;
                            nxt_mode  = mode;
                            nxt_run   = 1'b1;
                        end else begin
                            nxt_state = SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    // cnt counts samples after the entry sample, hence +2.
                    if (!ok_s) begin
                        nxt_state = IDLE;
                    end else if (cnt_p2 >= SETTLE_N) begin
                        nxt_state = RUN;
                        nxt_mode  = mode;
                        nxt_run   = 1'b1;
                    end
                end
                RUN: begin
                    if (!ok_s) begin
                        nxt_state = COOLDOWN;
                    end else if (cnt_p1 >= RUN_N) begin
                        nxt_state = COOLDOWN;
                        nxt_done  = 1'b1;
                    end else begin
                        nxt_run = 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (cnt_p1 >= COOL_N) begin
                        nxt_state = IDLE;
                    end
                end
                FAULT: begin
                    nxt_state = IDLE;
                end
                default: begin
                    nxt_state = IDLE;
                end
            endcase
        end

        if (nxt_state != state) begin
            nxt_cnt = '0;
        end
    end

    // All outputs are registered from next-state values so they line up
    // with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mode_q    <= 1'b0;
            dripper   <= 1'b0;
            sprinkler <= 1'b0;
            busy      <= 1'b0;
            fault     <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt_state;
            cnt       <= nxt_cnt;
            mode_q    <= nxt_mode;
            dripper   <= nxt_run && (nxt_mode == MODE_DRIP);
            sprinkler <= nxt_run && (nxt_mode == MODE_SPRINKLE);
            busy      <= is_busy(nxt_state);
            fault     <= (nxt_state == FAULT);
            done      <= nxt_done;
        end
    end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Scoreboard bench for irrigation_scheduler (default parameters, no sync).
// The stimulus process drives inputs on the falling edge and queues the
// hand-computed output vector expected after the following rising edge;
// the monitor pops and compares 2 time units after each rising edge.
// Vector layout: {dripper, sprinkler, busy, fault, done, state[2:0]}.
module tb_irrigation_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       irrigation_ok = 1'b0;
    logic       error = 1'b0;
    logic       mode = 1'b0;
    logic       dripper, sprinkler, busy, fault, done;
    logic [2:0] state;

    typedef struct {
        logic [7:0] v;
        string      tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    irrigation_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .irrigation_ok (irrigation_ok),
        .error         (error),
        .mode          (mode),
        .dripper       (dripper),
        .sprinkler     (sprinkler),
        .busy          (busy),
        .fault         (fault),
        .done          (done),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outs();
        return {dripper, sprinkler, busy, fault, done, state};
    endfunction

    function automatic void check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got d/s/b/f/dn/st=%b required %b at %0t", tag, act, exp, $time);
        end
    endfunction

    // Inputs for the next rising edge and the outputs expected after it.
    task automatic step(input logic ok, input logic err, input logic md,
                        input logic d, input logic s, input logic dn,
                        input logic [2:0] st, input string tag);
        exp_t e;
        logic b, f;
        @(negedge clk);
        irrigation_ok = ok;
        error         = err;
        mode          = md;
        b = (st == 3'd1) || (st == 3'd2) || (st == 3'd3);
        f = (st == 3'd4);
        e.v   = {d, s, b, f, dn, st};
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, outs(), e.v);
            end
        end
    end

    initial begin
        #3;
        check("reset_state", outs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 0, 0, 3'd0, "idle_after_reset");

        // 1: permit held, dripper, full run
        for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, 0, 3'd1, "t1_settle");
        for (int i = 4; i <= 19; i++) step(1, 0, 0, 1, 0, 0, 3'd2, "t1_run_drip");
        step(1, 0, 0, 0, 0, 1, 3'd3, "t1_done_pulse");
        for (int i = 21; i <= 27; i++) step(1, 0, 0, 0, 0, 0, 3'd3, "t1_cooldown");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t1_cool_to_idle");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t1_idle");

        // 2: sprinkler, permit drops at run cycle 5, permit ignored in cooldown
        for (int i = 1; i <= 3; i++) step(1, 0, 1, 0, 0, 0, 3'd1, "t2_settle");
        for (int i = 4; i <= 8; i++) step(1, 0, 1, 0, 1, 0, 3'd2, "t2_run_spr");
        step(0, 0, 1, 0, 0, 0, 3'd3, "t2_abort_no_done");
        for (int i = 10; i <= 16; i++) step(1, 0, 1, 0, 0, 0, 3'd3, "t2_cooldown_full");
        step(0, 0, 1, 0, 0, 0, 3'd0, "t2_cool_to_idle");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t2_idle");

        // 3: glitch in SETTLE restarts the count
        for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, 0, 3'd1, "t3_settle_a");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t3_glitch_idle");
        for (int i = 5; i <= 7; i++) step(1, 0, 0, 0, 0, 0, 3'd1, "t3_settle_b");
        step(1, 0, 0, 1, 0, 0, 3'd2, "t3_open_after_4");
        step(0, 0, 0, 0, 0, 0, 3'd3, "t3_abort");
        for (int i = 10; i <= 16; i++) step(0, 0, 0, 0, 0, 0, 3'd3, "t3_cooldown");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t3_idle");

        // 4: error during RUN, with permit falling on the same edge
        for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, 0, 3'd1, "t4_settle");
        step(1, 0, 0, 1, 0, 0, 3'd2, "t4_run");
        step(1, 0, 0, 1, 0, 0, 3'd2, "t4_run");
        step(0, 1, 0, 0, 0, 0, 3'd4, "t4_fault_wins");
        step(1, 1, 0, 0, 0, 0, 3'd4, "t4_fault_hold");
        step(1, 0, 0, 0, 0, 0, 3'd0, "t4_recover_idle");
        step(1, 0, 0, 0, 0, 0, 3'd1, "t4_new_settle");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t4_idle");

        // 5: mode toggles every cycle; dripper latched at entry (mode=0 on edge 4)
        for (int i = 1; i <= 3; i++) step(1, 0, i[0], 0, 0, 0, 3'd1, "t5_settle");
        for (int i = 4; i <= 19; i++) step(1, 0, i[0], 1, 0, 0, 3'd2, "t5_run_latched");
        step(1, 0, 1, 0, 0, 1, 3'd3, "t5_done");
        for (int i = 21; i <= 27; i++) step(0, 0, i[0], 0, 0, 0, 3'd3, "t5_cooldown");
        step(0, 0, 0, 0, 0, 0, 3'd0, "t5_idle");

        // 6: asynchronous reset between edges during RUN
        for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, 0, 3'd1, "t6_settle");
        step(1, 0, 0, 1, 0, 0, 3'd2, "t6_run");
        step(1, 0, 0, 1, 0, 0, 3'd2, "t6_run");
        @(posedge clk);
        #4;
        rst_n         = 1'b0;
        irrigation_ok = 1'b0;
        #1;
        check("t6_async_reset", outs(), 8'h00);
        #1;
        rst_n = 1'b1;
        #1;
        check("t6_state_at_release", outs(), 8'h00);
        step(0, 0, 0, 0, 0, 0, 3'd0, "t6_idle_after");

        // Drain the scoreboard within a bounded number of cycles.
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
